// File: rtl/prga_bitstream_programmer_if.sv
// Bitstream word stream (valid/ready) between a host-side source and the programmer.
interface prga_bitstream_programmer_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_ready;

  // Bitstream source side
  modport master (
    output bs_data,
    output bs_valid,
    input  bs_ready
  );

  // Programmer side
  modport slave (
    input  bs_data,
    input  bs_valid,
    output bs_ready
  );
endinterface

// File: rtl/prga_bitstream_programmer.sv
// Serial configuration programmer for the PRGA fabric scan chain.
// Pulses fab_prog_rst, shifts bitstream words MSB-first on fab_prog_we/din, then
// raises fab_prog_done. Optional echo check of the chain tail is enabled by
// defining PRGA_PROG_ECHO_CHECK_EN.
module prga_bitstream_programmer #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned ECHO_TMO   = 1024
) (
  input  logic                      prog_clk,
  input  logic                      prog_rst_n,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          total_bits_i,
  prga_bitstream_programmer_if.slave bs,
  output logic                      fab_prog_rst_o,
  output logic                      fab_prog_we_o,
  output logic                      fab_prog_din_o,
  output logic                      fab_prog_done_o,
  input  logic                      fab_prog_dout_i,
  input  logic                      fab_prog_we_o_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [CNT_W-1:0]          shifted_cnt_o
);

  localparam int unsigned NbW    = $clog2(WORD_W + 1);
  localparam int unsigned CycMax = (RST_CYCLES > ECHO_TMO) ? RST_CYCLES : ECHO_TMO;
  localparam int unsigned CycW   = $clog2(CycMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFrst,
    StLoad,
    StShift,
`ifdef PRGA_PROG_ECHO_CHECK_EN
    StDrain,
`endif
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [NbW-1:0]    nbits_q, nbits_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  shifted_cnt_q, shifted_cnt_d;
  // Shared cycle counter: FRST hold time and DRAIN timeout
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic              start_acc;

  assign start_acc = start_i && ((state_q == StIdle) || (state_q == StDone));

`ifdef PRGA_PROG_ECHO_CHECK_EN
  logic [CNT_W-1:0] total_q, echo_cnt_q, echo_cnt_d;
  logic             err_q, err_d;
  logic             dbg_dout_unused_q;

  // Count echoed write-enables from FRST exit until DONE
  always_comb begin
    echo_cnt_d = echo_cnt_q;
    if (start_acc) begin
      echo_cnt_d = '0;
    end else if (fab_prog_we_o_i &&
                 ((state_q == StLoad) || (state_q == StShift) || (state_q == StDrain))) begin
      echo_cnt_d = echo_cnt_q + CNT_W'(1);
    end
  end

  // Echo-check state: latched chain length, echo count, sticky error, debug sample
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      total_q           <= '0;
      echo_cnt_q        <= '0;
      err_q             <= 1'b0;
      dbg_dout_unused_q <= 1'b0;
    end else begin
      if (start_acc) total_q <= total_bits_i;
      echo_cnt_q        <= echo_cnt_d;
      err_q             <= err_d;
      dbg_dout_unused_q <= fab_prog_dout_i;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tail;
  assign unused_tail = fab_prog_dout_i ^ fab_prog_we_o_i;
  assign err_o       = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    nbits_d       = nbits_q;
    shreg_d       = shreg_q;
    shifted_cnt_d = shifted_cnt_q;
    cyc_d         = '0;
`ifdef PRGA_PROG_ECHO_CHECK_EN
    err_d         = err_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start_acc) begin
          rem_d         = total_bits_i;
          shifted_cnt_d = '0;
`ifdef PRGA_PROG_ECHO_CHECK_EN
          err_d         = 1'b0;
`endif
          state_d       = StFrst;
        end
      end
      StFrst: begin
        if (cyc_q == CycW'(RST_CYCLES - 1)) begin
          state_d = (rem_q == '0) ? StDone : StLoad;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StLoad: begin
        if (bs.bs_valid) begin
          shreg_d = bs.bs_data;
          nbits_d = (rem_q < CNT_W'(WORD_W)) ? NbW'(rem_q) : NbW'(WORD_W);
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d       = shreg_q << 1;
        rem_d         = rem_q - CNT_W'(1);
        nbits_d       = nbits_q - NbW'(1);
        shifted_cnt_d = shifted_cnt_q + CNT_W'(1);
        if (nbits_q == NbW'(1)) begin
`ifdef PRGA_PROG_ECHO_CHECK_EN
          state_d = (rem_q == CNT_W'(1)) ? StDrain : StLoad;
`else
          state_d = (rem_q == CNT_W'(1)) ? StDone : StLoad;
`endif
        end
      end
`ifdef PRGA_PROG_ECHO_CHECK_EN
      StDrain: begin
        if (echo_cnt_q == total_q) begin
          state_d = StDone;
        end else if (cyc_q == CycW'(ECHO_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      nbits_q       <= '0;
      shreg_q       <= '0;
      shifted_cnt_q <= '0;
      cyc_q         <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      nbits_q       <= nbits_d;
      shreg_q       <= shreg_d;
      shifted_cnt_q <= shifted_cnt_d;
      cyc_q         <= cyc_d;
    end
  end

  // Outputs decode straight from registered state, so async reset clears them at once
  assign bs.bs_ready      = (state_q == StLoad);
  assign fab_prog_rst_o   = (state_q == StFrst);
  assign fab_prog_we_o    = (state_q == StShift);
  assign fab_prog_din_o   = (state_q == StShift) && shreg_q[WORD_W-1];
  assign fab_prog_done_o  = (state_q == StDone);
  assign busy_o           = (state_q != StIdle) && (state_q != StDone);
  assign shifted_cnt_o    = shifted_cnt_q;

endmodule
